// File: rtl/plot_buffer_pkg.sv
// plot_pkg: shared constants, FIFO entry type and state enum
// for the plot_buffer framebuffer write stage.
package plot_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int FB_WORDS = 19200;
  localparam int FB_AW    = 15;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } pix_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CLEAR,
    DONE
  } state_e;

  // y*160 + x built from shifts: (y<<7)+(y<<5)+x
  function automatic logic [14:0] pix_addr(
    input logic [7:0] x,
    input logic [6:0] y
  );
    logic [14:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/plot_buffer_if.sv
// plot_buffer_if: framebuffer write port, valid/ready.
// master drives address/data/we, slave returns ready.
interface plot_buffer_if;
  import plot_pkg::*;

  logic [FB_AW-1:0] fb_addr;
  logic [2:0]       fb_data;
  logic             fb_we;
  logic             fb_ready;

  modport master (
    output fb_addr, fb_data, fb_we,
    input  fb_ready
  );

  modport slave (
    input  fb_addr, fb_data, fb_we,
    output fb_ready
  );

endinterface

// File: rtl/plot_buffer_fifo.sv
// plot_fifo: synchronous FIFO of pix_entry_t, DEPTH a power of 2.
// A push into a full FIFO succeeds only with a same-cycle pop.
module plot_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  pix_entry_t din_i,
  input  logic       pop_i,
  output pix_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [AW:0] count_o
);

  pix_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/plot_buffer.sv
// plot_buffer: pixel FIFO, holding register and clear-screen sweep.
// Optional PLOT_BUFFER_STATS_EN enables the saturating drop_count.
module plot_buffer
  import plot_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clr_start,
  input  logic [2:0]  clr_colour,
  output logic        clr_done,
  plot_buffer_if.master fb,
  output logic [AW:0] fifo_count,
  output logic        overflow,
  output logic [15:0] drop_count
);

  state_e      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [2:0]  data_q, data_d;
  logic        we_q, we_d;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  ccol_q, ccol_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic       in_range, push, pop, clr_acc;
  logic       xfer, can_load, drop_full;
  logic       f_full, f_empty;
  pix_entry_t f_din, f_head;

  assign in_range = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
  assign push     = vga_plot && in_range;
  assign f_din    = '{addr: pix_addr(vga_x, vga_y), colour: vga_colour};
  assign xfer     = we_q && fb.fb_ready;
  assign can_load = !we_q || xfer;
  assign drop_full = push && f_full && !pop;

  plot_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (f_din),
    .pop_i  (pop),
    .dout_o (f_head),
    .full_o (f_full),
    .empty_o(f_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q && !fb.fb_ready;
    cnt_d   = cnt_q;
    ccol_d  = ccol_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
    clr_acc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (can_load && !f_empty) begin
          pop    = 1'b1;
          addr_d = f_head.addr;
          data_d = f_head.colour;
          we_d   = 1'b1;
        end
        if (state_q == IDLE && clr_start) begin
          clr_acc = 1'b1;
          ccol_d  = clr_colour;
          done_d  = 1'b0;
          state_d = FLUSH;
        end else if (state_q == DONE && !clr_start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (!we_q) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // addr_q tracks cnt_q; the next word loads as the current one leaves
        if (!we_q) begin
          addr_d = cnt_q;
          data_d = ccol_q;
          we_d   = 1'b1;
        end else if (xfer) begin
          if (cnt_q == 15'(FB_WORDS - 1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = cnt_q + 1'b1;
            data_d = ccol_q;
            we_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (drop_full) ovf_d = 1'b1;
    if (clr_acc)   ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ccol_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ccol_q  <= ccol_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fb.fb_addr = addr_q;
  assign fb.fb_data = data_q;
  assign fb.fb_we   = we_q;
  assign clr_done   = done_q;
  assign overflow   = ovf_q;

`ifdef PLOT_BUFFER_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic        drop;

  assign drop = (vga_plot && !in_range) || drop_full;

  always_comb begin
    drop_d = drop_q;
    if (clr_acc)
      drop_d = '0;
    else if (drop && drop_q != 16'hFFFF)
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_plot_buffer.sv
// tb_plot_buffer: directed checks of push, overflow, clear sweep
// and asynchronous reset for plot_buffer.
module tb_plot_buffer;
  import plot_pkg::*;

`ifdef PLOT_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clr_start;
  logic [2:0]  clr_colour;
  logic        clr_done;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [14:0] wa_q[$];
  logic [2:0]  wd_q[$];

  plot_buffer_if fbi ();

  plot_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .clr_start (clr_start),
    .clr_colour(clr_colour),
    .clr_done  (clr_done),
    .fb        (fbi),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && fbi.fb_we === 1'b1 && fbi.fb_ready === 1'b1) begin
      wa_q.push_back(fbi.fb_addr);
      wd_q.push_back(fbi.fb_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
    clr_start = 1'b0; clr_colour = '0;
    fbi.fb_ready = 1'b1;
    #22;
    checks++;
    if (fbi.fb_we !== 1'b0) begin
      errors++; $display("FAIL rst_we got %0b want 0", fbi.fb_we);
    end
    checks++;
    if (fbi.fb_addr !== 15'd0) begin
      errors++; $display("FAIL rst_addr got %0d want 0", fbi.fb_addr);
    end
    checks++;
    if (fbi.fb_data !== 3'd0) begin
      errors++; $display("FAIL rst_data got %0d want 0", fbi.fb_data);
    end
    checks++;
    if (clr_done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %0b want 0", clr_done);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got %0b want 0", overflow);
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++; $display("FAIL rst_count got %0d want 0", fifo_count);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++; $display("FAIL rst_drop got %0d want 0", drop_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_single();
    clr_log();
    fbi.fb_ready = 1'b1;
    vga_x = 8'd10; vga_y = 7'd5; vga_colour = 3'd3; vga_plot = 1'b1;
    cyc(1);
    vga_plot = 1'b0;
    checks++;
    if (fbi.fb_we !== 1'b0) begin
      errors++; $display("FAIL single_n1_we got %0b want 0", fbi.fb_we);
    end
    cyc(1);
    checks++;
    if (fbi.fb_we !== 1'b1 || fbi.fb_addr !== 15'd810 || fbi.fb_data !== 3'd3) begin
      errors++;
      $display("FAIL single_n2 got we=%0b addr=%0d data=%0d want 1/810/3",
               fbi.fb_we, fbi.fb_addr, fbi.fb_data);
    end
    cyc(4);
    checks++;
    if (wa_q.size() != 1) begin
      errors++; $display("FAIL single_count got %0d want 1", wa_q.size());
    end else if (wa_q[0] !== 15'd810 || wd_q[0] !== 3'd3) begin
      errors++;
      $display("FAIL single_write got %0d/%0d want 810/3", wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_corners();
    clr_log();
    vga_plot = 1'b1;
    vga_x = 8'd0;   vga_y = 7'd0;   vga_colour = 3'd1; cyc(1);
    vga_x = 8'd159; vga_y = 7'd119; vga_colour = 3'd6; cyc(1);
    vga_x = 8'd160; vga_y = 7'd0;   vga_colour = 3'd7; cyc(1);
    vga_x = 8'd0;   vga_y = 7'd120; vga_colour = 3'd2; cyc(1);
    vga_plot = 1'b0;
    cyc(6);
    checks++;
    if (wa_q.size() != 2) begin
      errors++; $display("FAIL corner_count got %0d want 2", wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 15'd0 || wd_q[0] !== 3'd1) begin
        errors++;
        $display("FAIL corner_first got %0d/%0d want 0/1", wa_q[0], wd_q[0]);
      end
      checks++;
      if (wa_q[1] !== 15'd19199 || wd_q[1] !== 3'd6) begin
        errors++;
        $display("FAIL corner_last got %0d/%0d want 19199/6", wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL corner_ovf got %0b want 0", overflow);
    end
    checks++;
    if (drop_count !== (STATS ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL corner_drop got %0d want %0d", drop_count, STATS ? 2 : 0);
    end
  endtask

  task automatic test_overflow();
    int bad;
    clr_log();
    fbi.fb_ready = 1'b0;
    vga_plot = 1'b1;
    for (int i = 0; i < 18; i++) begin
      vga_x = 8'(i); vga_y = 7'd10; vga_colour = 3'(i);
      cyc(1);
    end
    vga_plot = 1'b0;
    cyc(1);
    checks++;
    if (fifo_count !== 5'd16) begin
      errors++; $display("FAIL ovf_count got %0d want 16", fifo_count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %0b want 1", overflow);
    end
    checks++;
    if (fbi.fb_we !== 1'b1 || fbi.fb_addr !== 15'd1600 || fbi.fb_data !== 3'd0) begin
      errors++;
      $display("FAIL ovf_hold got we=%0b addr=%0d data=%0d want 1/1600/0",
               fbi.fb_we, fbi.fb_addr, fbi.fb_data);
    end
    checks++;
    if (drop_count !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("FAIL ovf_drop got %0d want %0d", drop_count, STATS ? 3 : 0);
    end
    checks++;
    if (wa_q.size() != 0) begin
      errors++; $display("FAIL ovf_stall got %0d writes want 0", wa_q.size());
    end
    fbi.fb_ready = 1'b1;
    cyc(25);
    checks++;
    if (wa_q.size() != 17) begin
      errors++; $display("FAIL ovf_drain got %0d writes want 17", wa_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 17; i++)
        if (wa_q[i] !== 15'(1600 + i) || wd_q[i] !== 3'(i)) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL ovf_order got %0d bad entries want 0", bad);
      end
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++; $display("FAIL ovf_empty got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_clear();
    int bad;
    bit seen;
    clr_log();
    fbi.fb_ready = 1'b1;
    clr_colour = 3'd5;
    clr_start = 1'b1;
    cyc(3);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_ovf got %0b want 0", overflow);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      errors++; $display("FAIL clr_drop got %0d want 0", drop_count);
    end
    cyc(7);
    vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd2; vga_plot = 1'b1;
    cyc(1);
    vga_plot = 1'b0;
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++; $display("FAIL clr_buffered got %0d want 1", fifo_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 25000 && !seen; i++) begin
      cyc(1);
      if (clr_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL clr_timeout got done=%0b want 1", clr_done);
    end
    cyc(5);
    checks++;
    if (clr_done !== 1'b1) begin
      errors++; $display("FAIL clr_hold got %0b want 1", clr_done);
    end
    checks++;
    if (wa_q.size() != 19201) begin
      errors++; $display("FAIL clr_count got %0d want 19201", wa_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 19200; i++)
        if (wa_q[i] !== 15'(i) || wd_q[i] !== 3'd5) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL clr_sweep got %0d bad words want 0", bad);
      end
      checks++;
      if (wa_q[19200] !== 15'd161 || wd_q[19200] !== 3'd2) begin
        errors++;
        $display("FAIL clr_after got %0d/%0d want 161/2",
                 wa_q[19200], wd_q[19200]);
      end
    end
    clr_start = 1'b0;
    cyc(2);
    checks++;
    if (clr_done !== 1'b0) begin
      errors++; $display("FAIL clr_release got %0b want 0", clr_done);
    end
  endtask

  task automatic test_reset_mid();
    fbi.fb_ready = 1'b1;
    clr_colour = 3'd4;
    clr_start = 1'b1;
    cyc(50);
    checks++;
    if (fbi.fb_we !== 1'b1) begin
      errors++; $display("FAIL mid_active got %0b want 1", fbi.fb_we);
    end
    #2;
    rst_n = 1'b0;
    clr_start = 1'b0;
    #1;
    checks++;
    if (fbi.fb_we !== 1'b0 || fbi.fb_addr !== 15'd0 || fbi.fb_data !== 3'd0) begin
      errors++;
      $display("FAIL mid_clr_rst got we=%0b addr=%0d data=%0d want 0/0/0",
               fbi.fb_we, fbi.fb_addr, fbi.fb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr_log();
    cyc(20);
    checks++;
    if (wa_q.size() != 0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_clr_resume got %0d writes done=%0b want 0/0",
               wa_q.size(), clr_done);
    end
    fbi.fb_ready = 1'b0;
    vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd4; vga_plot = 1'b1;
    cyc(1);
    vga_plot = 1'b0;
    cyc(3);
    checks++;
    if (fbi.fb_we !== 1'b1 || fbi.fb_addr !== 15'd483) begin
      errors++;
      $display("FAIL mid_stall got we=%0b addr=%0d want 1/483",
               fbi.fb_we, fbi.fb_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fbi.fb_we !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall_rst got we=%0b cnt=%0d ovf=%0b want 0/0/0",
               fbi.fb_we, fifo_count, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr_log();
    fbi.fb_ready = 1'b1;
    cyc(10);
    checks++;
    if (wa_q.size() != 0) begin
      errors++; $display("FAIL mid_stall_resume got %0d writes want 0", wa_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_overflow();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
